// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer.
//   DW_DEF / AW_DEF : default data and register-address widths
//   op_e            : micro-op encoding (3 bits)
//   state_e         : sequencer FSM states
package regfile_seq_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Micro-op handshake between the instruction/control source and the sequencer.
//   in_valid : micro-op present (source -> sequencer)
//   in_ready : sequencer idle, micro-op accepted on an edge where both are high
//   op       : operation code
//   rd       : destination register
//   rs1, rs2 : source registers
//   imm      : immediate for MOV
// Modports: master = instruction source, slave = sequencer.
interface regfile_sequencer_if
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;

    modport master (
        output in_valid, op, rd, rs1, rs2, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, imm,
        output in_ready
    );
endinterface

// File: rtl/regfile_sequencer_alu.sv
// seq_alu: purely combinational ALU of the sequencer.
//   op     : operation (op_e)
//   a, b   : operands read from the register file
//   imm    : immediate, used by MOV only
//   result : DW-bit result, wraps modulo 2**DW
//   carry  : carry out (ADD), borrow (SUB/CMP), shifted-out bit (SHL), else 0
//   zero   : result == 0
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    // One bit wider than the operands so the top bit is the carry, or the
    // borrow for a subtraction (it is set exactly when a < b unsigned).
    logic [DW:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV: result = imm;
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DW-1:0];
                carry  = ext[DW];
            end
            OP_SUB, OP_CMP: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DW-1:0];
                carry  = ext[DW];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                carry  = a[DW-1];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: initiator for a 4 x 8-bit register file.
// Accepts one micro-op per handshake, reads two operands, computes an ALU
// result and writes it back, taking four cycles per op
// (IDLE -> READ -> EXEC -> WRITE).
//   clk, reset     : clock, asynchronous active-high reset
//   uop            : micro-op handshake (slave side)
//   ra1, ra2       : read addresses, hold the captured rs1/rs2
//   rd1, rd2       : read data, combinational from ra1/ra2
//   ra3, wd3       : write address/data, held between writes
//   we3_n          : active-low write enable, low only in WRITE (never for CMP)
//   result, flags  : last computed result, zero and carry/borrow flags
//   done           : one-cycle pulse in the cycle after WRITE
//   busy           : ~in_ready
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_sequencer_if.slave   uop,
    output logic [AW-1:0]        ra1,
    output logic [AW-1:0]        ra2,
    input  logic [DW-1:0]        rd1,
    input  logic [DW-1:0]        rd2,
    output logic [AW-1:0]        ra3,
    output logic [DW-1:0]        wd3,
    output logic                 we3_n,
    output logic [DW-1:0]        result,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 done,
    output logic                 busy
);

    state_e        state_reg, state_next;

    op_e           op_reg;
    logic [AW-1:0] rd_reg;
    logic [AW-1:0] ra1_reg;
    logic [AW-1:0] ra2_reg;
    logic [DW-1:0] imm_reg;
    logic [DW-1:0] opa_reg;
    logic [DW-1:0] opb_reg;
    logic [DW-1:0] result_reg;
    logic          flag_z_reg;
    logic          flag_c_reg;
    logic [AW-1:0] ra3_reg;
    logic [DW-1:0] wd3_reg;
    logic          done_reg;

    logic          in_ready_c;
    logic          we3_n_c;

    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;

    seq_alu #(.DW(DW)) u_alu (
        .op     (op_reg),
        .a      (opa_reg),
        .b      (opb_reg),
        .imm    (imm_reg),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (uop.in_valid) state_next = ST_READ;
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready_c = (state_reg == ST_IDLE);
        we3_n_c    = 1'b1;
        if (state_reg == ST_WRITE && op_reg != OP_CMP) begin
            we3_n_c = 1'b0;
        end
    end

    // Datapath registers. A reset clears every captured field, so an op
    // interrupted by reset leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg     <= OP_MOV;
            rd_reg     <= '0;
            ra1_reg    <= '0;
            ra2_reg    <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
            ra3_reg    <= '0;
            wd3_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_WRITE);
            case (state_reg)
                ST_IDLE: begin
                    if (uop.in_valid) begin
                        op_reg  <= op_e'(uop.op);
                        rd_reg  <= uop.rd;
                        ra1_reg <= uop.rs1;
                        ra2_reg <= uop.rs2;
                        imm_reg <= uop.imm;
                    end
                end
                ST_READ: begin
                    opa_reg <= rd1;
                    opb_reg <= rd2;
                end
                ST_EXEC: begin
                    result_reg <= alu_result;
                    flag_z_reg <= alu_zero;
                    flag_c_reg <= alu_carry;
                    // Write address/data move only for ops that write, so a
                    // CMP leaves the previous write-port values in place.
                    if (op_reg != OP_CMP) begin
                        ra3_reg <= rd_reg;
                        wd3_reg <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uop.in_ready = in_ready_c;
    assign busy         = ~in_ready_c;
    assign we3_n        = we3_n_c;
    assign ra1          = ra1_reg;
    assign ra2          = ra2_reg;
    assign ra3          = ra3_reg;
    assign wd3          = wd3_reg;
    assign result       = result_reg;
    assign flag_z       = flag_z_reg;
    assign flag_c       = flag_c_reg;
    assign done         = done_reg;

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator for the 4 x 8-bit register file. Accepts one micro-op per valid/ready handshake, reads operands through the two read ports, computes an 8-bit result and writes it back through the write port.
- Sits between the instruction/control source and the register file.
- Also exports the result, zero/carry flags and a completion pulse.

Parameters:
- DW, 8, data width of registers, operands and result
- AW, 2, register address width (4 registers)

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  micro-op present
- in_ready  output  1  sequencer idle, can accept a micro-op
- op  input  3  operation code
- rd  input  AW  destination register
- rs1  input  AW  source register 1
- rs2  input  AW  source register 2
- imm  input  DW  immediate for MOV
- ra1  output  AW  register file read address 1
- ra2  output  AW  register file read address 2
- rd1  input  DW  register file read data 1 (combinational from ra1)
- rd2  input  DW  register file read data 2 (combinational from ra2)
- ra3  output  AW  register file write address
- wd3  output  DW  register file write data
- we3_n  output  1  register file write enable, active-low (the register file writes on the clk edge while low)
- result  output  DW  last computed result
- flag_z  output  1  last result == 0
- flag_c  output  1  carry/borrow of last operation
- done  output  1  one-cycle pulse on completion
- busy  output  1  operation in progress (equals ~in_ready)

Behaviour:
- States: IDLE, READ, EXEC, WRITE.
- IDLE: in_ready=1. If in_valid at the edge, capture op/rd/rs1/rs2/imm and go to READ. Otherwise stay in IDLE; inputs are ignored.
- READ: ra1=rs1, ra2=rs2 from the captured fields. Latch rd1/rd2 into operand registers at the edge, then go to EXEC.
- EXEC: compute with the ALU, register result/flag_z/flag_c at the edge, then go to WRITE.
- WRITE: ra3=rd, wd3=result, we3_n=0 for exactly this one cycle, except CMP, which keeps we3_n=1. Go to IDLE; done=1 during the following cycle only.
- ra1/ra2 hold their captured values outside READ. ra3/wd3 are held when not writing.
- Latency: accept at edge E0; write at edge E3; done high in the cycle after E3. The next accept is possible at E4, so throughput is one op per 4 cycles.
- No read-after-write hazard: a write at E3 is visible to a READ after E4.
- in_valid asserted while busy is not captured and is not lost by the sequencer; the source must hold it until in_ready.
- Ops (all 8-bit, results wrap modulo 256):
  - 000 MOV: result=imm, C=0
  - 001 ADD: 9-bit sum, result=sum[7:0], C=sum[8]
  - 010 SUB: result=a-b, C=borrow (a<b unsigned)
  - 011 AND, 100 OR, 101 XOR: C=0
  - 110 SHL: result=a<<1, C=a[7]
  - 111 CMP: computes a-b flags only, no write
- flag_z = (result==0) for all ops. Flags and result hold until the next EXEC.
- Reset values:
  - state IDLE, in_ready=1, busy=0, done=0
  - ra1=ra2=ra3=0, wd3=0, we3_n=1
  - result=0, flag_z=0, flag_c=0
- Reset mid-operation: abort immediately, no write (we3_n=1), no done pulse, and captured fields are discarded.

Decomposition:
- Package regfile_seq_pkg holds:
  - DW/AW defaults
  - op_e enum (MOV, ADD, SUB, AND, OR, XOR, SHL, CMP)
  - state_e enum (IDLE, READ, EXEC, WRITE)
- One combinational sub-module, seq_alu: inputs op, a, b, imm; outputs result, carry, zero.
- The FSM and registers stay in regfile_sequencer.

Test Plan:
- Bench instantiates the sequencer connected to a behavioural 4x8 register file with active-low write and reset-to-zero.
1. Reset, then MOV rd=2 imm=0x5A -> WRITE cycle shows ra3=2, wd3=0x5A, we3_n=0 for one cycle; done pulses one cycle later; r2=0x5A, Z=0, C=0.
2. r1=0xF0, r2=0x20, ADD rd=3 rs1=1 rs2=2 -> r3=0x10, C=1, Z=0. SHL of r1 into r0 -> r0=0xE0, C=1.
3. r1=r2=0x05, SUB rd=0 -> r0=0x00, Z=1, C=0. Then r1=0x03, SUB -> 0xFE, C=1, Z=0.
4. CMP rs1=1 rs2=2 with values 0x05/0x05 -> Z=1, we3_n stays 1 for the whole op, all registers unchanged, done still pulses.
5. in_valid held high with back-to-back ops (MOV r0=0x11, then ADD r1=r0+r0) -> second op accepted the cycle after done; in_ready low 3 cycles; r1=0x22.
6. Reset asserted during EXEC of ADD -> we3_n never low, no done pulse, target register unchanged, in_ready=1 and all outputs at reset values after release.
